// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: iterates a one-position SLL/SRL/SRA/ROL once per clock
// until the requested amount is consumed, then pulses done with the final result.
module shift_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] step_val;
    logic             step_carry;

    // One-position step of the captured operation on the working register.
    always_comb begin
        step_val   = work_q;
        step_carry = 1'b0;
        unique case (op_q)
            2'b00: begin
                step_val   = {work_q[WIDTH-2:0], 1'b0};
                step_carry = work_q[WIDTH-1];
            end
            2'b01: begin
                step_val   = {1'b0, work_q[WIDTH-1:1]};
                step_carry = work_q[0];
            end
            2'b10: begin
                step_val   = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_carry = work_q[0];
            end
            2'b11: begin
                step_val   = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                step_carry = work_q[WIDTH-1];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            work_q    <= '0;
            op_q      <= 2'b00;
            cnt_q     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        work_q <= data_in;
                        op_q   <= op;
                        cnt_q  <= amount;
                        if (amount == '0) begin
                            state_q   <= StDone;
                            result    <= data_in;
                            carry_out <= 1'b0;
                            zero      <= (data_in == '0);
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    work_q <= step_val;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    // Last step: publish result as we enter DONE.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q   <= StDone;
                        result    <= step_val;
                        carry_out <= step_carry;
                        zero      <= (step_val == '0);
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] data_in;
    logic [2:0] amount;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;

    int total = 0;
    int bad   = 0;

    shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .data_in   (data_in),
        .amount    (amount),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Whole-shift result computed directly from the amount, not by iteration.
    function automatic void model(input logic [1:0] o, input logic [7:0] d, input int a,
                                  output logic [7:0] r, output logic c);
        logic signed [7:0] s;
        int n;
        s = d;
        c = 1'b0;
        case (o)
            2'b00: begin
                r = (a >= 8) ? 8'h00 : 8'(d << a);
                if (a > 0 && a <= 8) c = d[8-a];
            end
            2'b01: begin
                r = (a >= 8) ? 8'h00 : (d >> a);
                if (a > 0 && a <= 8) c = d[a-1];
            end
            2'b10: begin
                r = (a >= 8) ? {8{d[7]}} : 8'(s >>> a);
                if (a > 0) c = (a <= 8) ? d[a-1] : d[7];
            end
            default: begin
                n = a % 8;
                r = (n == 0) ? d : 8'((d << n) | (d >> (8 - n)));
                if (a > 0) c = r[0];
            end
        endcase
    endfunction

    // Issue one request, watch it to completion; optionally jiggle inputs while busy.
    task automatic do_op(input logic [1:0] o, input logic [7:0] d, input logic [2:0] a,
                         input bit noise);
        logic [7:0] er;
        logic       ec;
        int         lat;
        int         pulses;
        int         amt;
        amt = int'(a);
        model(o, d, amt, er, ec);
        @(negedge clk);
        op = o; data_in = d; amount = a; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        pulses = 0;
        for (int k = 1; k <= amt + 3; k++) begin
            if (done) begin
                pulses++;
                if (lat == 0) lat = k;
            end
            check("busy", busy, (k <= amt + 1) ? 1 : 0);
            if (noise && k <= amt + 1) begin
                start   = 1'($urandom);
                op      = 2'($urandom);
                data_in = 8'($urandom);
                amount  = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("latency", lat, amt + 1);
        check("done_pulses", pulses, 1);
        check("result", result, er);
        check("carry_out", carry_out, ec);
        check("zero", zero, (er == 8'h00) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; data_in = 8'h00; amount = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 8'h00);
        check("rst_carry", carry_out, 0);
        check("rst_zero", zero, 1);
        rst_n = 1'b1;

        do_op(2'b00, 8'h81, 3'd1, 1'b0);
        check("sll_81_1", result, 8'h02);
        do_op(2'b10, 8'h90, 3'd3, 1'b0);
        check("sra_90_3", result, 8'hF2);
        do_op(2'b11, 8'hA5, 3'd7, 1'b0);
        check("rol_a5_7", result, 8'hD2);
        do_op(2'b11, 8'h3C, 3'd0, 1'b0);
        check("amt0", result, 8'h3C);
        do_op(2'b01, 8'h01, 3'd1, 1'b1);
        check("srl_01_1_c", carry_out, 1);
        check("srl_01_1_z", zero, 1);
        do_op(2'b10, 8'h7F, 3'd7, 1'b1);

        // Result must hold across idle cycles.
        repeat (3) @(negedge clk);
        check("hold_result", result, 8'h00);

        // Reset during the third SHIFT cycle aborts the operation.
        do_op(2'b11, 8'hF0, 3'd2, 1'b0);
        @(negedge clk);
        op = 2'b00; data_in = 8'h5A; amount = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 8'h00);
        check("abort_zero", zero, 1);
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                if (done) seen++;
                @(negedge clk);
            end
            check("abort_no_done", seen, 0);
        end
        do_op(2'b00, 8'h0F, 3'd4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
